// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ttt_pkg
// Summary  : Shared types and direction tables for the tic-tac-toe move engine.
// Revision : 1.0
// ============================================================================
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        X     = 2'd1,
        O     = 2'd2
    } cell_t;

    typedef enum logic [2:0] {
        RES_OK           = 3'd0,
        RES_WIN          = 3'd1,
        RES_DRAW         = 3'd2,
        RES_ILL_OCCUPIED = 3'd3,
        RES_ILL_RANGE    = 3'd4,
        RES_ILL_TURN     = 3'd5,
        RES_ILL_OVER     = 3'd6
    } res_code_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        FWD    = 3'd2,
        BWD    = 3'd3,
        NEXT   = 3'd4,
        REPORT = 3'd5
    } state_t;

    // Two-bit signed deltas packed dir3..dir0: (0,+1) (+1,0) (+1,+1) (+1,-1)
    localparam logic [7:0] c_DIR_DR = 8'b01_01_01_00;
    localparam logic [7:0] c_DIR_DC = 8'b11_01_00_01;

    function automatic logic signed [1:0] dir_dr(input logic [1:0] dir);
        return $signed(c_DIR_DR[{dir, 1'b0} +: 2]);
    endfunction

    function automatic logic signed [1:0] dir_dc(input logic [1:0] dir);
        return $signed(c_DIR_DC[{dir, 1'b0} +: 2]);
    endfunction

    function automatic cell_t player_cell(input logic player);
        return player ? O : X;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_board.sv
`default_nettype none
// ============================================================================
// Module   : ttt_board
// Summary  : N x N cell store, one synchronous write port, two async reads.
// Revision : 1.0
// ============================================================================
module ttt_board
    import ttt_pkg::*;
#(
    parameter int N  = 3,
    parameter int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [RW-1:0] i_wr_row,
    input  logic [RW-1:0] i_wr_col,
    input  cell_t         i_wr_data,
    input  logic [RW-1:0] i_wk_row,
    input  logic [RW-1:0] i_wk_col,
    output cell_t         o_wk_cell,
    input  logic [RW-1:0] i_rd_row,
    input  logic [RW-1:0] i_rd_col,
    output cell_t         o_rd_cell
);

    localparam int          c_CELLS = N * N;
    localparam int          c_AW    = $clog2(c_CELLS);
    localparam logic [RW:0] c_N     = (RW+1)'(N);

    cell_t r_cells [c_CELLS];

    function automatic logic [c_AW-1:0] cell_idx(input logic [RW-1:0] row, input logic [RW-1:0] col);
        return c_AW'(row) * c_AW'(N) + c_AW'(col);
    endfunction

    function automatic logic in_range(input logic [RW-1:0] row, input logic [RW-1:0] col);
        return ({1'b0, row} < c_N) && ({1'b0, col} < c_N);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < c_CELLS; i++) begin
                r_cells[i] <= EMPTY;
            end
        end else if (i_we) begin
            r_cells[cell_idx(i_wr_row, i_wr_col)] <= i_wr_data;
        end
    end

    assign o_wk_cell = in_range(i_wk_row, i_wk_col) ? r_cells[cell_idx(i_wk_row, i_wk_col)] : EMPTY;
    assign o_rd_cell = in_range(i_rd_row, i_rd_col) ? r_cells[cell_idx(i_rd_row, i_rd_col)] : EMPTY;

endmodule
`default_nettype wire

// File: rtl/ttt_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : ttt_move_engine
// Summary  : N x N, K-in-a-row move validator; walks the four lines through
//            each placed cell one step per clock and reports the outcome.
// Revision : 1.0
// ============================================================================
module ttt_move_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_game,
    input  logic          mv_valid,
    output logic          mv_ready,
    input  logic          mv_player,
    input  logic [RW-1:0] mv_row,
    input  logic [RW-1:0] mv_col,
    output logic          res_valid,
    output logic [2:0]    res_code,
    output logic          res_player,
    output logic          turn,
    output logic          game_over,
    input  logic [RW-1:0] rd_row,
    input  logic [RW-1:0] rd_col,
    output logic [1:0]    rd_cell
);
    import ttt_pkg::*;

    localparam logic [RW:0] c_N     = (RW+1)'(N);
    localparam logic [4:0]  c_K     = 5'(K);
    localparam logic [7:0]  c_CELLS = 8'(N * N);

    state_t                r_state;
    logic [RW-1:0]         r_row, r_col;
    logic                  r_player;
    logic signed [RW:0]    r_wr, r_wc;
    logic [1:0]            r_dir;
    logic [4:0]            r_run;
    logic [7:0]            r_moves;
    res_code_t             r_code;
    logic                  r_turn, r_over;
    logic                  r_res_valid, r_res_player;
    logic [2:0]            r_res_code;

    logic signed [RW:0]    w_dr, w_dc, w_nr, w_nc;
    logic signed [RW:0]    w_home_r, w_home_c;
    logic                  w_n_in, w_match, w_we;
    logic [RW-1:0]         w_wk_row, w_wk_col;
    cell_t                 w_wk_cell, w_rd_cell;
    res_code_t             w_check_code;

    assign w_dr     = (RW+1)'(dir_dr(r_dir));
    assign w_dc     = (RW+1)'(dir_dc(r_dir));
    assign w_nr     = (r_state == BWD) ? r_wr - w_dr : r_wr + w_dr;
    assign w_nc     = (r_state == BWD) ? r_wc - w_dc : r_wc + w_dc;
    assign w_home_r = $signed({1'b0, r_row});
    assign w_home_c = $signed({1'b0, r_col});

    // Negative coordinates show up as a set sign bit; no wrap-around onto the board.
    assign w_n_in   = !w_nr[RW] && !w_nc[RW] && ($unsigned(w_nr) < c_N) && ($unsigned(w_nc) < c_N);
    assign w_match  = w_n_in && (w_wk_cell == player_cell(r_player));

    // The walk port doubles as the occupancy probe while in CHECK.
    assign w_wk_row = (r_state == CHECK) ? r_row : w_nr[RW-1:0];
    assign w_wk_col = (r_state == CHECK) ? r_col : w_nc[RW-1:0];

    always_comb begin
        w_check_code = RES_OK;
        if (r_over) begin
            w_check_code = RES_ILL_OVER;
        end else if (({1'b0, r_row} >= c_N) || ({1'b0, r_col} >= c_N)) begin
            w_check_code = RES_ILL_RANGE;
        end else if (r_player != r_turn) begin
            w_check_code = RES_ILL_TURN;
        end else if (w_wk_cell != EMPTY) begin
            w_check_code = RES_ILL_OCCUPIED;
        end
    end

    assign w_we = (r_state == CHECK) && (w_check_code == RES_OK);

    ttt_board #(
        .N  (N),
        .RW (RW)
    ) u_board (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (new_game),
        .i_we      (w_we),
        .i_wr_row  (r_row),
        .i_wr_col  (r_col),
        .i_wr_data (player_cell(r_player)),
        .i_wk_row  (w_wk_row),
        .i_wk_col  (w_wk_col),
        .o_wk_cell (w_wk_cell),
        .i_rd_row  (rd_row),
        .i_rd_col  (rd_col),
        .o_rd_cell (w_rd_cell)
    );

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_player     <= 1'b0;
            r_wr         <= '0;
            r_wc         <= '0;
            r_dir        <= 2'd0;
            r_run        <= 5'd0;
            r_moves      <= 8'd0;
            r_code       <= RES_OK;
            r_turn       <= 1'b0;
            r_over       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_code   <= 3'd0;
            r_res_player <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mv_valid) begin
                        r_row    <= mv_row;
                        r_col    <= mv_col;
                        r_player <= mv_player;
                        r_state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_check_code != RES_OK) begin
                        r_code  <= w_check_code;
                        r_state <= REPORT;
                    end else begin
                        r_moves <= r_moves + 8'd1;
                        r_wr    <= w_home_r;
                        r_wc    <= w_home_c;
                        r_dir   <= 2'd0;
                        r_run   <= 5'd1;
                        r_state <= FWD;
                    end
                end
                // Leave a walk as soon as the run reaches K, so a win skips the rest.
                FWD: begin
                    if (w_match) begin
                        r_run <= r_run + 5'd1;
                        r_wr  <= w_nr;
                        r_wc  <= w_nc;
                        if (r_run + 5'd1 >= c_K) begin
                            r_state <= NEXT;
                        end
                    end else begin
                        r_wr    <= w_home_r;
                        r_wc    <= w_home_c;
                        r_state <= BWD;
                    end
                end
                BWD: begin
                    if (w_match) begin
                        r_run <= r_run + 5'd1;
                        r_wr  <= w_nr;
                        r_wc  <= w_nc;
                        if (r_run + 5'd1 >= c_K) begin
                            r_state <= NEXT;
                        end
                    end else begin
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_run >= c_K) begin
                        r_code  <= RES_WIN;
                        r_state <= REPORT;
                    end else if (r_dir == 2'd3) begin
                        r_code  <= (r_moves == c_CELLS) ? RES_DRAW : RES_OK;
                        r_state <= REPORT;
                    end else begin
                        r_dir   <= r_dir + 2'd1;
                        r_run   <= 5'd1;
                        r_wr    <= w_home_r;
                        r_wc    <= w_home_c;
                        r_state <= FWD;
                    end
                end
                REPORT: begin
                    r_res_valid  <= 1'b1;
                    r_res_code   <= r_code;
                    r_res_player <= r_player;
                    if (r_code == RES_OK) begin
                        r_turn <= ~r_turn;
                    end else if ((r_code == RES_WIN) || (r_code == RES_DRAW)) begin
                        r_over <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mv_ready   = (r_state == IDLE);
    assign res_valid  = r_res_valid;
    assign res_code   = r_res_code;
    assign res_player = r_res_player;
    assign turn       = r_turn;
    assign game_over  = r_over;
    assign rd_cell    = w_rd_cell;

endmodule
`default_nettype wire

// File: tb/tb_ttt_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttt_move_engine
// Summary  : Table-driven scoreboard bench for a 3x3/K=3 and a 5x5/K=4 engine.
// Revision : 1.0
// ============================================================================
module tb_ttt_move_engine;

    localparam logic [2:0] c_OK = 3'd0, c_WIN = 3'd1, c_DRAW = 3'd2, c_OCC = 3'd3,
                           c_RNG = 3'd4, c_TRN = 3'd5, c_OVR = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, new_game, mv_valid, mv_player, sel;
    logic [1:0] a_row, a_col, a_rdr, a_rdc;
    logic [2:0] b_row, b_col, b_rdr, b_rdc;

    logic       a_ready, a_rv, a_rp, a_turn, a_over;
    logic [2:0] a_code;
    logic [1:0] a_cell;
    logic       b_ready, b_rv, b_rp, b_turn, b_over;
    logic [2:0] b_code;
    logic [1:0] b_cell;

    logic       ready, rv, rp, turn_m, over_m;
    logic [2:0] code_m;
    logic [1:0] cell_m;

    ttt_move_engine #(.N(3), .K(3)) dut3 (
        .clk(clk), .rst(rst), .new_game(new_game),
        .mv_valid(mv_valid && !sel), .mv_ready(a_ready), .mv_player(mv_player),
        .mv_row(a_row), .mv_col(a_col),
        .res_valid(a_rv), .res_code(a_code), .res_player(a_rp),
        .turn(a_turn), .game_over(a_over),
        .rd_row(a_rdr), .rd_col(a_rdc), .rd_cell(a_cell)
    );

    ttt_move_engine #(.N(5), .K(4)) dut5 (
        .clk(clk), .rst(rst), .new_game(new_game),
        .mv_valid(mv_valid && sel), .mv_ready(b_ready), .mv_player(mv_player),
        .mv_row(b_row), .mv_col(b_col),
        .res_valid(b_rv), .res_code(b_code), .res_player(b_rp),
        .turn(b_turn), .game_over(b_over),
        .rd_row(b_rdr), .rd_col(b_rdc), .rd_cell(b_cell)
    );

    assign ready  = sel ? b_ready : a_ready;
    assign rv     = sel ? b_rv    : a_rv;
    assign rp     = sel ? b_rp    : a_rp;
    assign turn_m = sel ? b_turn  : a_turn;
    assign over_m = sel ? b_over  : a_over;
    assign code_m = sel ? b_code  : a_code;
    assign cell_m = sel ? b_cell  : a_cell;

    typedef struct {
        logic [2:0] code;
        logic       pl;
        int         acc;
        int         maxlat;
        bit         exact;
    } exp_t;

    typedef struct {
        bit         ng;
        bit         d5;
        bit         pl;
        int         r;
        int         c;
        logic [2:0] code;
        bit         turn;
        bit         over;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];
    exp_t m_e;
    int   checks = 0, errors = 0, cyc = 0, res_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input bit ng, input bit d5, input bit pl, input int r, input int c,
                                input logic [2:0] code, input bit tn, input bit ov);
        vec_t v;
        v.ng = ng; v.d5 = d5; v.pl = pl; v.r = r; v.c = c;
        v.code = code; v.turn = tn; v.over = ov;
        return v;
    endfunction

    // Scoreboard: every result pulse must match the oldest outstanding move.
    always @(negedge clk) begin
        if (rv === 1'b1) begin
            res_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got code %0d, required no result", code_m);
            end else begin
                m_e = sbq.pop_front();
                chk("res_code", 32'(code_m), 32'(m_e.code));
                chk("res_player", 32'(rp), 32'(m_e.pl));
                if (m_e.exact) begin
                    chk("illegal_latency", 32'(cyc - m_e.acc), 32'(m_e.maxlat));
                end else begin
                    checks++;
                    if (cyc - m_e.acc > m_e.maxlat) begin
                        errors++;
                        $display("FAIL legal_latency: got %0d required <= %0d", cyc - m_e.acc, m_e.maxlat);
                    end
                end
            end
        end
    end

    task automatic set_addr(input int r, input int c);
        a_row = 2'(r); a_col = 2'(c);
        b_row = 3'(r); b_col = 3'(c);
    endtask

    task automatic pulse_ng();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic rd_check(input int r, input int c, input int exp);
        a_rdr = 2'(r); a_rdc = 2'(c);
        b_rdr = 3'(r); b_rdc = 3'(c);
        #1;
        chk($sformatf("rd_cell(%0d,%0d)", r, c), 32'(cell_m), 32'(exp));
    endtask

    task automatic wait_ready();
        int w = 0;
        while (ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic move(input bit pl, input int r, input int c, input logic [2:0] code);
        exp_t e;
        int   kk;
        int   w;
        wait_ready();
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: mv_ready got %b required 1", ready);
            return;
        end
        kk       = sel ? 4 : 3;
        e.code   = code;
        e.pl     = pl;
        e.acc    = cyc + 1;
        e.exact  = (code >= 3'd3);
        e.maxlat = e.exact ? 2 : 2 + 4 * (2 * (kk - 1) + 1);
        sbq.push_back(e);
        mv_valid  = 1'b1;
        mv_player = pl;
        set_addr(r, c);
        @(negedge clk);
        mv_valid  = 1'b0;
        mv_player = 1'($urandom);
        set_addr($urandom_range(0, 7), $urandom_range(0, 7));
        w = 0;
        while (sbq.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: outstanding %0d results, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; new_game = 1'b0; mv_valid = 1'b0; mv_player = 1'b0; sel = 1'b0;
        set_addr(0, 0);
        a_rdr = '0; a_rdc = '0; b_rdr = '0; b_rdc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_mv_ready", 32'(ready), 1);
        chk("reset_res_valid", 32'(rv), 0);
        chk("reset_res_code", 32'(code_m), 0);
        chk("reset_res_player", 32'(rp), 0);
        chk("reset_turn", 32'(turn_m), 0);
        chk("reset_game_over", 32'(over_m), 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                rd_check(r, c, 0);
        @(negedge clk);

        // ng, dut5, player, row, col, code, turn after, game_over after
        vt.push_back(mk(1, 0, 0, 0, 0, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 1, 0, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 0, 2, c_WIN, 0, 1));
        vt.push_back(mk(0, 0, 1, 2, 2, c_OVR, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 0, c_TRN, 0, 0));
        vt.push_back(mk(0, 0, 0, 3, 0, c_RNG, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 3, c_RNG, 0, 0));
        vt.push_back(mk(0, 0, 1, 3, 3, c_RNG, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 0, 2, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 1, 1, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 2, 0, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 2, 1, c_OK,  1, 0));
        vt.push_back(mk(0, 0, 1, 1, 2, c_OK,  0, 0));
        vt.push_back(mk(0, 0, 0, 2, 2, c_DRAW, 0, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, c_OVR, 0, 1));
        vt.push_back(mk(1, 1, 0, 0, 3, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 0, 0, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 1, 2, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 4, 4, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 2, 1, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 2, 4, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 3, 0, c_WIN, 0, 1));
        vt.push_back(mk(1, 1, 0, 0, 4, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 0, 0, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 1, 3, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 2, 2, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 3, 3, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 4, 0, c_OK,  1, 0));
        vt.push_back(mk(0, 1, 1, 4, 4, c_OK,  0, 0));
        vt.push_back(mk(0, 1, 0, 3, 1, c_WIN, 0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].ng) pulse_ng();
            sel = vt[i].d5;
            move(vt[i].pl, vt[i].r, vt[i].c, vt[i].code);
            chk($sformatf("turn_vec%0d", i), 32'(turn_m), 32'(vt[i].turn));
            chk($sformatf("game_over_vec%0d", i), 32'(over_m), 32'(vt[i].over));
        end

        // Occupied cell: board and turn must be untouched by the rejected move.
        sel = 1'b0;
        pulse_ng();
        move(1'b0, 1, 1, c_OK);
        move(1'b1, 1, 1, c_OCC);
        chk("occupied_turn", 32'(turn_m), 1);
        rd_check(1, 1, 1);
        rd_check(0, 0, 0);
        rd_check(3, 1, 0);
        @(negedge clk);

        // new_game during the line walk aborts the move with no result.
        pulse_ng();
        move(1'b0, 2, 2, c_OK);
        wait_ready();
        base = res_count;
        mv_valid = 1'b1; mv_player = 1'b1; set_addr(0, 0);
        @(negedge clk);
        mv_valid = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("abort_mv_ready", 32'(ready), 1);
        chk("abort_turn", 32'(turn_m), 0);
        chk("abort_game_over", 32'(over_m), 0);
        repeat (30) @(negedge clk);
        chk("abort_no_result", 32'(res_count), 32'(base));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                rd_check(r, c, 0);
        @(negedge clk);

        // new_game coincident with an accept drops the move.
        base = res_count;
        mv_valid = 1'b1; mv_player = 1'b0; set_addr(0, 1);
        new_game = 1'b1;
        @(negedge clk);
        mv_valid = 1'b0; new_game = 1'b0;
        repeat (20) @(negedge clk);
        chk("ng_accept_no_result", 32'(res_count), 32'(base));
        rd_check(0, 1, 0);
        chk("ng_accept_mv_ready", 32'(ready), 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
